// File: rtl/gearbox_tx_sched.sv
// Transmit-side sequencer for the 32-bit 10GBASE-R TX gearbox: splits 66-bit blocks into
// word pairs on a 33-cycle cadence (32 enabled + 1 drain) and substitutes idle blocks on underflow.
module gearbox_tx_sched #(
  parameter logic [1:0]  IDLE_HDR     = 2'b10,
  parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [63:0]          blk_data,
  input  logic [1:0]           blk_hdr,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic [31:0]          gb_din,
  output logic [1:0]           gb_ctrl,
  output logic                 gb_din_en,
  output logic                 gb_even,
  output logic [5:0]           slot,
  output logic                 running,
  output logic                 underflow,
  output logic [ERR_CNT_W-1:0] underflow_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [5:0] LAST_DATA_SLOT = 6'd31;
  localparam logic [5:0] DRAIN_SLOT     = 6'd32;

  state_e                 state_q, state_d;
  logic [5:0]             slot_q, slot_d;
  logic [63:0]            pl_q, pl_d;
  logic [1:0]             hdr_q, hdr_d;
  logic                   blk_ready_q, blk_ready_d;
  logic [31:0]            din_q, din_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic                   en_q, en_d;
  logic                   even_q, even_d;
  logic                   running_q, running_d;
  logic                   underflow_q, underflow_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   even_slot_s;

  always_comb begin
    state_d     = state_q;
    slot_d      = 6'd0;
    pl_d        = pl_q;
    hdr_d       = hdr_q;
    blk_ready_d = 1'b0;
    din_d       = 32'd0;
    ctrl_d      = 2'b00;
    en_d        = 1'b0;
    even_d      = 1'b0;
    underflow_d = 1'b0;
    cnt_d       = cnt_q;
    even_slot_s = 1'b0;

    // A registered blk_ready is itself the fetch strobe: the block (or idle filler) lands in the holding register.
    if (blk_ready_q) begin
      if (blk_valid) begin
        pl_d  = blk_data;
        hdr_d = blk_hdr;
      end else begin
        pl_d        = IDLE_PAYLOAD;
        hdr_d       = IDLE_HDR;
        underflow_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + ERR_CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
    end else begin
      pl_d  = pl_q;
      hdr_d = hdr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_en) begin
          state_d     = ST_START;
          blk_ready_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_RUN;
        slot_d  = 6'd0;
      end
      ST_RUN: begin
        // A fetch at the drain slot commits to another sequence; otherwise stop.
        if (slot_q == DRAIN_SLOT) begin
          if (blk_ready_q) begin
            slot_d = 6'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_RUN) begin
      if (slot_d == DRAIN_SLOT) begin
        blk_ready_d = tx_en;
      end else begin
        blk_ready_d = slot_d[0] && (slot_d != LAST_DATA_SLOT);
        even_slot_s = ~slot_d[0];
        en_d        = 1'b1;
        even_d      = even_slot_s;
        din_d       = even_slot_s ? pl_d[31:0] : pl_d[63:32];
        ctrl_d      = even_slot_s ? hdr_d : 2'b00;
      end
    end else begin
      blk_ready_d = blk_ready_d;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= 6'd0;
      pl_q        <= 64'd0;
      hdr_q       <= 2'b00;
      blk_ready_q <= 1'b0;
      din_q       <= 32'd0;
      ctrl_q      <= 2'b00;
      en_q        <= 1'b0;
      even_q      <= 1'b0;
      running_q   <= 1'b0;
      underflow_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pl_q        <= pl_d;
      hdr_q       <= hdr_d;
      blk_ready_q <= blk_ready_d;
      din_q       <= din_d;
      ctrl_q      <= ctrl_d;
      en_q        <= en_d;
      even_q      <= even_d;
      running_q   <= running_d;
      underflow_q <= underflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign blk_ready     = blk_ready_q;
  assign gb_din        = din_q;
  assign gb_ctrl       = ctrl_q;
  assign gb_din_en     = en_q;
  assign gb_even       = even_q;
  assign slot          = slot_q;
  assign running       = running_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_gearbox_tx_sched.sv
// Self-checking bench for gearbox_tx_sched: startup vector table, directed corner sequences,
// and randomized traffic compared every cycle against a sequence-level reference model.
module tb_gearbox_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tx_en, blk_valid;
  logic [63:0] blk_data;
  logic [1:0]  blk_hdr;

  logic        blk_ready, gb_din_en, gb_even, running, underflow;
  logic [31:0] gb_din;
  logic [1:0]  gb_ctrl;
  logic [5:0]  slot;
  logic [15:0] underflow_cnt;

  logic        r4_ready, r4_en, r4_even, r4_running, r4_underflow;
  logic [31:0] r4_din;
  logic [1:0]  r4_ctrl;
  logic [5:0]  r4_slot;
  logic [3:0]  r4_cnt;

  gearbox_tx_sched dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .blk_data(blk_data), .blk_hdr(blk_hdr),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .gb_din(gb_din), .gb_ctrl(gb_ctrl),
    .gb_din_en(gb_din_en), .gb_even(gb_even), .slot(slot), .running(running),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  gearbox_tx_sched #(.ERR_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .tx_en(tx_en), .blk_data(blk_data), .blk_hdr(blk_hdr),
    .blk_valid(blk_valid), .blk_ready(r4_ready), .gb_din(r4_din), .gb_ctrl(r4_ctrl),
    .gb_din_en(r4_en), .gb_even(r4_even), .slot(r4_slot), .running(r4_running),
    .underflow(r4_underflow), .underflow_cnt(r4_cnt)
  );

  localparam logic [63:0] IDLE_PL = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_HD = 2'b10;

  int errors = 0;
  int checks = 0;

  // Reference model: where we are in the 33-slot sequence and which block is held.
  bit          m_start, m_run, m_ready, m_und;
  int          m_slot, m_cnt;
  logic [63:0] m_pl;
  logic [1:0]  m_hd;

  int k  = 0;   // next payload index for patterned traffic
  int fc = 0;   // fetch cycles seen (blk_ready high across an edge)

  typedef struct {
    logic        tx_en;
    logic        valid;
    int          pay_idx;
    logic        exp_ready;
    logic        exp_en;
    logic        exp_even;
    logic [5:0]  exp_slot;
    logic [31:0] exp_din;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [63:0] pay(input int idx);
    logic [31:0] i32;
    i32 = idx[31:0];
    return {32'hA000_0000 + i32, 32'hB000_0000 + i32};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit          fetch, en, ev;
    logic [31:0] din;
    logic [1:0]  ctl;
    logic [63:0] act, exp, act4;
    fetch = m_ready;
    m_und = 1'b0;
    if (!rst) begin
      m_start = 1'b0; m_run = 1'b0; m_ready = 1'b0; m_slot = 0; m_cnt = 0;
    end else begin
      if (fetch) begin
        if (blk_valid) begin
          m_pl = blk_data; m_hd = blk_hdr;
        end else begin
          m_pl = IDLE_PL; m_hd = IDLE_HD; m_und = 1'b1; m_cnt++;
        end
      end
      if (m_start) begin
        m_start = 1'b0; m_run = 1'b1; m_slot = 0;
      end else if (m_run) begin
        if (m_slot == 32) begin
          if (fetch) m_slot = 0;
          else begin m_run = 1'b0; m_slot = 0; end
        end else begin
          m_slot++;
        end
      end else if (tx_en) begin
        m_start = 1'b1;
      end
      m_ready = m_start || (m_run && (((m_slot % 2) == 1 && m_slot != 31) || (m_slot == 32 && tx_en)));
    end
    @(posedge clk);
    #1;
    en  = m_run && m_slot < 32;
    ev  = en && (m_slot % 2) == 0;
    din = !en ? 32'd0 : (ev ? m_pl[31:0] : m_pl[63:32]);
    ctl = ev ? m_hd : 2'b00;
    exp  = 64'({m_ready, din, ctl, en, ev, 6'(m_slot), m_run, m_und});
    act  = 64'({blk_ready, gb_din, gb_ctrl, gb_din_en, gb_even, slot, running, underflow});
    act4 = 64'({r4_ready, r4_din, r4_ctrl, r4_en, r4_even, r4_slot, r4_running, r4_underflow});
    chk("model_outputs", act, exp);
    chk("model_outputs_w4", act4, exp);
    chk("model_cnt16", 64'(underflow_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("model_cnt4", 64'(r4_cnt), 64'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  task automatic feed_step();
    bit rd;
    rd = blk_ready;
    blk_data = pay(k);
    blk_hdr  = 2'b01;
    step();
    if (rd) fc++;
    if (rd && blk_valid) k++;
  endtask

  task automatic wait_slot(input logic [5:0] s, input string name);
    for (int i = 0; i < 40 && !(running && slot == s); i++) feed_step();
    chk(name, 64'({running, slot}), 64'({1'b1, s}));
  endtask

  initial begin
    int en_cnt, hs0, up;
    bit seen32;
    rst = 1'b0; tx_en = 1'b0; blk_valid = 1'b1; blk_data = 64'd0; blk_hdr = 2'b00;
    m_start = 1'b0; m_run = 1'b0; m_ready = 1'b0; m_und = 1'b0;
    m_slot = 0; m_cnt = 0; m_pl = 64'd0; m_hd = 2'b00;

    // Reset state
    step();
    chk("reset_outputs", 64'({blk_ready, gb_din, gb_ctrl, gb_din_en, gb_even, slot, running, underflow}), 64'd0);
    chk("reset_cnt", 64'(underflow_cnt), 64'd0);
    rst = 1'b1;
    step();

    // Startup: ready in the startup cycle, then slot 0 carrying the first block
    vecs[0] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b1, 6'd0, 32'hB000_0000};
    vecs[2] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 6'd1, 32'hA000_0000};
    vecs[3] = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 6'd2, 32'hB000_0001};
    vecs[4] = '{1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 6'd3, 32'hA000_0001};
    for (int i = 0; i < 5; i++) begin
      tx_en = vecs[i].tx_en; blk_valid = vecs[i].valid;
      blk_data = pay(vecs[i].pay_idx); blk_hdr = 2'b01;
      step();
      chk($sformatf("startup_v%0d", i),
          64'({blk_ready, gb_din_en, gb_even, slot, gb_din}),
          64'({vecs[i].exp_ready, vecs[i].exp_en, vecs[i].exp_even, vecs[i].exp_slot, vecs[i].exp_din}));
    end
    chk("startup_ctrl_odd", 64'(gb_ctrl), 64'd0);
    k = 2;

    // Continuous traffic: two full 33-cycle periods
    en_cnt = 0; hs0 = fc;
    for (int i = 0; i < 66; i++) begin
      feed_step();
      if (gb_din_en) en_cnt++;
    end
    chk("cont_en_cycles", 64'(en_cnt), 64'd64);
    chk("cont_handshakes", 64'(fc - hs0), 64'd32);
    chk("cont_no_underflow", 64'(underflow_cnt), 64'd0);

    // Underflow at the slot-5 fetch
    wait_slot(6'd5, "uf_reach_slot5");
    chk("uf_ready_slot5", 64'(blk_ready), 64'd1);
    blk_valid = 1'b0;
    feed_step();
    blk_valid = 1'b1;
    chk("uf_even_word", 64'({slot, gb_din, gb_ctrl, underflow}), 64'({6'd6, 32'h0000_001E, 2'b10, 1'b1}));
    chk("uf_cnt", 64'(underflow_cnt), 64'd1);
    feed_step();
    chk("uf_odd_word", 64'({slot, gb_din, gb_ctrl, underflow}), 64'({6'd7, 32'h0, 2'b00, 1'b0}));

    // Graceful stop: tx_en drops at slot 10, sequence completes
    wait_slot(6'd10, "stop_reach_slot10");
    tx_en = 1'b0; fc = 0; seen32 = 1'b0;
    for (int i = 0; i < 40 && running; i++) begin
      feed_step();
      if (running && slot == 6'd32) begin
        seen32 = 1'b1;
        chk("stop_s32", 64'({blk_ready, gb_din_en, gb_din}), 64'd0);
      end
    end
    chk("stop_seen32", 64'(seen32), 64'd1);
    chk("stop_fetches", 64'(fc), 64'd10);
    chk("stop_idle", 64'({running, gb_din_en, blk_ready}), 64'd0);
    feed_step();
    chk("stop_stays_idle", 64'({running, gb_din_en, blk_ready}), 64'd0);

    // Reset mid-run at slot 17, then restart from slot 0
    tx_en = 1'b1;
    wait_slot(6'd17, "rst_reach_slot17");
    rst = 1'b0;
    feed_step();
    chk("rst_mid_outputs", 64'({blk_ready, gb_din, gb_ctrl, gb_din_en, gb_even, slot, running, underflow}), 64'd0);
    chk("rst_mid_cnt", 64'(underflow_cnt), 64'd0);
    rst = 1'b1;
    feed_step();
    chk("restart_startup", 64'({blk_ready, running, gb_din_en}), 64'({1'b1, 1'b0, 1'b0}));
    feed_step();
    chk("restart_slot0", 64'({running, gb_din_en, gb_even, slot}), 64'({1'b1, 1'b1, 1'b1, 6'd0}));

    // Saturation of the 4-bit counter under sustained underflow
    rst = 1'b0; feed_step(); rst = 1'b1;
    blk_valid = 1'b0; fc = 0; up = 0;
    for (int i = 0; i < 45; i++) begin
      feed_step();
      if (underflow) up++;
    end
    chk("sat_enough_slots", 64'(fc >= 20), 64'd1);
    chk("sat_cnt4", 64'(r4_cnt), 64'hF);
    chk("sat_pulses", 64'(up), 64'(fc));
    chk("sat_cnt16", 64'(underflow_cnt), 64'(fc));
    blk_valid = 1'b1;

    // Randomized traffic, enables and occasional resets
    for (int i = 0; i < 900; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      tx_en     = ($urandom_range(0, 9) != 0);
      blk_valid = ($urandom_range(0, 3) != 0);
      blk_data  = {$urandom, $urandom};
      blk_hdr   = 2'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
